// File: rtl/mine_neighbor_counter.sv
// Minesweeper adjacency counter for a 5x5 board: snapshots a mine bitmap and
// writes one cell's neighbour count (or 4'hF for a mine) per falling clock edge.
module mine_neighbor_counter (
    input  logic         in_clka,
    input  logic         in_rst_n,
    input  logic         in_start,
    input  logic [24:0]  in_mines,
    output logic [99:0]  out_counts,
    output logic [4:0]   out_mine_total,
    output logic         out_busy,
    output logic         out_done,
    output logic         out_valid,
    output logic         dbg_state
);

    // Handshake: in_start is accepted only while idle (out_busy=0); the scan then
    // runs 25 edges with out_busy=1, ends with a one-cycle out_done pulse, and
    // out_valid stays high until the next accepted start.
    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t      state;
    logic [24:0] snapshot;
    logic [4:0]  index;
    logic [2:0]  row;
    logic [2:0]  col;
    logic [3:0]  nb_sum;

    assign dbg_state = state;

    // Sum the in-bounds 3x3 window around (row, col), excluding the centre.
    always_comb begin : nb_calc
        int r;
        int c;
        logic [4:0] nb_idx;
        nb_sum = '0;
        r      = 0;
        c      = 0;
        nb_idx = '0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                r      = int'(row) + dr - 1;
                c      = int'(col) + dc - 1;
                nb_idx = 5'(r * 5 + c);
                if (!(dr == 1 && dc == 1) && r >= 0 && r <= 4 && c >= 0 && c <= 4)
                    nb_sum = nb_sum + {3'b000, snapshot[nb_idx]};
            end
        end
    end

    always_ff @(negedge in_clka) begin
        if (!in_rst_n) begin
            state          <= IDLE;
            snapshot       <= '0;
            index          <= '0;
            row            <= '0;
            col            <= '0;
            out_counts     <= '0;
            out_mine_total <= '0;
            out_busy       <= 1'b0;
            out_done       <= 1'b0;
            out_valid      <= 1'b0;
        end else begin
            out_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_start) begin
                        snapshot       <= in_mines;
                        out_counts     <= '0;
                        out_mine_total <= '0;
                        index          <= '0;
                        row            <= '0;
                        col            <= '0;
                        out_busy       <= 1'b1;
                        out_valid      <= 1'b0;
                        state          <= SCAN;
                    end
                end
                SCAN: begin
                    if (snapshot[index]) begin
                        out_counts[{index, 2'b00} +: 4] <= 4'hF;
                        out_mine_total                  <= out_mine_total + 5'd1;
                    end else begin
                        out_counts[{index, 2'b00} +: 4] <= nb_sum;
                    end
                    if (index == 5'd24) begin
                        out_done  <= 1'b1;
                        out_valid <= 1'b1;
                        out_busy  <= 1'b0;
                        index     <= '0;
                        row       <= '0;
                        col       <= '0;
                        state     <= IDLE;
                    end else begin
                        index <= index + 5'd1;
                        // row/col track index so the neighbour window needs no divider
                        if (col == 3'd4) begin
                            col <= '0;
                            row <= row + 3'd1;
                        end else begin
                            col <= col + 3'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mine_neighbor_counter.sv
// Bench for mine_neighbor_counter: directed boards, random boards and protocol
// scenarios checked against a padded-grid reference model.
module tb_mine_neighbor_counter;

    logic         in_clka;
    logic         in_rst_n;
    logic         in_start;
    logic [24:0]  in_mines;
    logic [99:0]  out_counts;
    logic [4:0]   out_mine_total;
    logic         out_busy;
    logic         out_done;
    logic         out_valid;
    logic         dbg_state;

    int errors = 0;
    int checks = 0;

    mine_neighbor_counter dut (
        .in_clka        (in_clka),
        .in_rst_n       (in_rst_n),
        .in_start       (in_start),
        .in_mines       (in_mines),
        .out_counts     (out_counts),
        .out_mine_total (out_mine_total),
        .out_busy       (out_busy),
        .out_done       (out_done),
        .out_valid      (out_valid),
        .dbg_state      (dbg_state)
    );

    // Clock / reset block: DUT acts on negedge, bench drives and samples on posedge.
    initial begin
        in_clka = 1'b0;
        forever #5 in_clka = ~in_clka;
    end

    // Reference model: 7x7 zero-padded grid, 3x3 window sum minus the centre.
    function automatic logic [99:0] model_counts(input logic [24:0] m);
        int g [0:6][0:6];
        int s;
        logic [99:0] res;
        res = '0;
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 7; c++) g[r][c] = 0;
        for (int i = 0; i < 25; i++) g[i / 5 + 1][i % 5 + 1] = int'(m[i]);
        for (int i = 0; i < 25; i++) begin
            if (m[i]) begin
                res[4 * i +: 4] = 4'hF;
            end else begin
                s = 0;
                for (int r = i / 5; r <= i / 5 + 2; r++)
                    for (int c = i % 5; c <= i % 5 + 2; c++) s += g[r][c];
                s -= g[i / 5 + 1][i % 5 + 1];
                res[4 * i +: 4] = 4'(s);
            end
        end
        return res;
    endfunction

    function automatic logic [3:0] field(input logic [99:0] v, input int i);
        return v[4 * i +: 4];
    endfunction

    // Driver: one-cycle start, then observe up to 40 edges (k = edges after E0).
    task automatic start_and_wait(input logic [24:0] m, output int done_at,
                                  output int busy_cnt, output int done_cnt);
        @(posedge in_clka);
        in_start = 1'b1;
        in_mines = m;
        @(posedge in_clka);
        in_start = 1'b0;
        done_at  = -1;
        busy_cnt = 0;
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (out_busy) busy_cnt++;
            if (out_done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (done_at >= 0 && k >= done_at + 1) break;
            @(posedge in_clka);
        end
    endtask

    task automatic test_reset();
        in_rst_n = 1'b0;
        in_start = 1'b0;
        in_mines = '0;
        repeat (3) @(posedge in_clka);
        checks++;
        if ({out_counts, out_mine_total, out_busy, out_done, out_valid, dbg_state} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got counts=%h total=%0d busy=%b done=%b valid=%b state=%b, expected all 0",
                     out_counts, out_mine_total, out_busy, out_done, out_valid, dbg_state);
        end
        in_rst_n = 1'b1;
        @(posedge in_clka);
    endtask

    task automatic test_empty();
        int d, b, n;
        start_and_wait(25'h0, d, b, n);
        checks++;
        if (d !== 25) begin errors++; $display("FAIL empty_latency: got %0d expected 25", d); end
        checks++;
        if (b !== 25) begin errors++; $display("FAIL empty_busy_cycles: got %0d expected 25", b); end
        checks++;
        if (n !== 1) begin errors++; $display("FAIL empty_done_width: got %0d expected 1", n); end
        checks++;
        if (out_counts !== '0 || out_mine_total !== 5'd0) begin
            errors++;
            $display("FAIL empty_result: got %h/%0d expected 0/0", out_counts, out_mine_total);
        end
        checks++;
        if (out_valid !== 1'b1 || out_busy !== 1'b0) begin
            errors++;
            $display("FAIL empty_flags: got valid=%b busy=%b expected 1/0", out_valid, out_busy);
        end
    endtask

    task automatic test_centre();
        int d, b, n;
        logic [99:0] exp_c;
        exp_c = '0;
        foreach (exp_c[i]) exp_c[i] = 1'b0;
        exp_c[4 * 6 +: 4]  = 4'd1; exp_c[4 * 7 +: 4]  = 4'd1; exp_c[4 * 8 +: 4]  = 4'd1;
        exp_c[4 * 11 +: 4] = 4'd1; exp_c[4 * 13 +: 4] = 4'd1; exp_c[4 * 16 +: 4] = 4'd1;
        exp_c[4 * 17 +: 4] = 4'd1; exp_c[4 * 18 +: 4] = 4'd1; exp_c[4 * 12 +: 4] = 4'hF;
        start_and_wait(25'h1 << 12, d, b, n);
        checks++;
        if (out_counts !== exp_c) begin
            errors++;
            $display("FAIL centre_counts: got %h expected %h", out_counts, exp_c);
        end
        checks++;
        if (out_mine_total !== 5'd1) begin
            errors++;
            $display("FAIL centre_total: got %0d expected 1", out_mine_total);
        end
    endtask

    task automatic test_edge_wrap();
        int d, b, n;
        logic [24:0] m;
        m = (25'h1 << 4) | (25'h1 << 20);
        start_and_wait(m, d, b, n);
        checks++;
        if (field(out_counts, 3) !== 4'd1 || field(out_counts, 8) !== 4'd1 || field(out_counts, 9) !== 4'd1 ||
            field(out_counts, 15) !== 4'd1 || field(out_counts, 16) !== 4'd1 || field(out_counts, 21) !== 4'd1) begin
            errors++;
            $display("FAIL edge_neighbours: got %h expected cells 3,8,9,15,16,21 = 1", out_counts);
        end
        checks++;
        if (field(out_counts, 5) !== 4'd0 || field(out_counts, 10) !== 4'd0 || field(out_counts, 24) !== 4'd0) begin
            errors++;
            $display("FAIL edge_no_wrap: got c5=%0d c10=%0d c24=%0d expected 0",
                     field(out_counts, 5), field(out_counts, 10), field(out_counts, 24));
        end
        checks++;
        if (field(out_counts, 4) !== 4'hF || field(out_counts, 20) !== 4'hF || out_mine_total !== 5'd2) begin
            errors++;
            $display("FAIL edge_mines: got c4=%h c20=%h total=%0d expected F F 2",
                     field(out_counts, 4), field(out_counts, 20), out_mine_total);
        end
        checks++;
        if (out_counts !== model_counts(m)) begin
            errors++;
            $display("FAIL edge_model: got %h expected %h", out_counts, model_counts(m));
        end
    endtask

    task automatic test_full();
        int d, b, n;
        logic [99:0] all_f;
        all_f = '1;
        start_and_wait(25'h1FFFFFF, d, b, n);
        checks++;
        if (out_counts !== all_f || out_mine_total !== 5'd25) begin
            errors++;
            $display("FAIL full_board: got %h/%0d expected all F/25", out_counts, out_mine_total);
        end
        start_and_wait(25'h0FFFFFF, d, b, n);
        checks++;
        if (field(out_counts, 24) !== 4'd3 || out_mine_total !== 5'd24) begin
            errors++;
            $display("FAIL corner_clear: got c24=%0d total=%0d expected 3/24",
                     field(out_counts, 24), out_mine_total);
        end
    endtask

    task automatic test_random();
        int d, b, n;
        logic [24:0] m;
        for (int t = 0; t < 16; t++) begin
            m = 25'($urandom);
            if (t % 2 == 0) m = m & 25'($urandom);
            start_and_wait(m, d, b, n);
            checks++;
            if (out_counts !== model_counts(m) || out_mine_total !== 5'($countones(m)) || d !== 25) begin
                errors++;
                $display("FAIL random_%0d: mines=%h got %h/%0d lat=%0d expected %h/%0d lat=25",
                         t, m, out_counts, out_mine_total, d, model_counts(m), $countones(m));
            end
        end
        // Results must hold in IDLE.
        repeat ($urandom_range(3, 8)) @(posedge in_clka);
        checks++;
        if (out_counts !== model_counts(m) || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL idle_hold: got %h valid=%b expected %h valid=1", out_counts, out_valid, model_counts(m));
        end
    endtask

    task automatic test_protocol();
        logic [24:0] m;
        int done_at, done_cnt, extra;
        m = 25'($urandom);
        @(posedge in_clka);
        in_start = 1'b1;
        in_mines = m;
        @(posedge in_clka);
        in_start = 1'b0;
        done_at  = -1;
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            in_start = (k == 3 || k == 12 || k == 20);
            if (k == 7) in_mines = ~m;
            if (k == 15) in_mines = 25'($urandom);
            if (out_done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (done_at >= 0 && k >= done_at + 1) break;
            @(posedge in_clka);
        end
        in_start = 1'b0;
        extra = 0;
        repeat (30) begin
            @(posedge in_clka);
            if (out_done || out_busy) extra++;
        end
        checks++;
        if (done_at !== 25 || done_cnt !== 1 || extra !== 0) begin
            errors++;
            $display("FAIL ignore_start: got done_at=%0d dones=%0d extra=%0d expected 25/1/0", done_at, done_cnt, extra);
        end
        checks++;
        if (out_counts !== model_counts(m) || out_mine_total !== 5'($countones(m))) begin
            errors++;
            $display("FAIL snapshot: got %h/%0d expected %h/%0d", out_counts, out_mine_total,
                     model_counts(m), $countones(m));
        end
    endtask

    task automatic test_back_to_back();
        int exp_q[$];
        int got_q[$];
        logic [24:0] m;
        int wait_k;
        m = 25'($urandom);
        exp_q = '{25, 51, 77};
        @(posedge in_clka);
        in_start = 1'b1;
        in_mines = m;
        for (int k = 0; k < 86; k++) begin
            @(posedge in_clka);
            if (out_done) got_q.push_back(k);
        end
        in_start = 1'b0;
        wait_k = 0;
        while (!(out_done) && wait_k < 40) begin
            @(posedge in_clka);
            wait_k++;
        end
        checks++;
        if (got_q !== exp_q) begin
            errors++;
            $display("FAIL back_to_back: got %0d dones first=%0d expected done at 25,51,77",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : -1);
        end
        checks++;
        if (wait_k >= 40 || out_counts !== model_counts(m)) begin
            errors++;
            $display("FAIL back_to_back_tail: got wait=%0d counts=%h expected done within 40 and %h",
                     wait_k, out_counts, model_counts(m));
        end
    endtask

    task automatic test_reset_mid_scan();
        int d, b, n;
        logic [24:0] m;
        m = 25'($urandom);
        @(posedge in_clka);
        in_start = 1'b1;
        in_mines = m;
        @(posedge in_clka);
        in_start = 1'b0;
        repeat (9) @(posedge in_clka);
        checks++;
        if (out_busy !== 1'b1 || dbg_state !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_busy: got busy=%b state=%b expected 1/1", out_busy, dbg_state);
        end
        in_rst_n = 1'b0;
        in_start = 1'b1;
        @(posedge in_clka);
        checks++;
        if ({out_counts, out_mine_total, out_busy, out_done, out_valid, dbg_state} !== '0) begin
            errors++;
            $display("FAIL mid_scan_reset: got counts=%h total=%0d busy=%b done=%b valid=%b state=%b expected all 0",
                     out_counts, out_mine_total, out_busy, out_done, out_valid, dbg_state);
        end
        in_rst_n = 1'b1;
        in_start = 1'b0;
        m = 25'($urandom);
        start_and_wait(m, d, b, n);
        checks++;
        if (d !== 25 || out_counts !== model_counts(m) || out_mine_total !== 5'($countones(m))) begin
            errors++;
            $display("FAIL after_reset_scan: got lat=%0d %h/%0d expected 25 %h/%0d",
                     d, out_counts, out_mine_total, model_counts(m), $countones(m));
        end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_centre();
        test_edge_wrap();
        test_full();
        test_random();
        test_protocol();
        test_back_to_back();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mine_neighbor_counter.md
# mine_neighbor_counter

Downstream consumer of the mine-placement RNG. Snapshots the 25-bit mine bitmap of the 5x5 board and walks it one cell per clock. For each cell it produces the classic Minesweeper adjacency number: the count of mines among its up-to-8 neighbours. The resulting per-cell counts and the total mine count feed the board display/reveal logic.

## Interface
- No parameters; board fixed at 5x5 (25 cells), cell index = row*5 + col, row/col 0..4.
- in_clka  input  1  clock; all state updates on falling edge of in_clka.
- in_rst_n  input  1  reset, synchronous, active-low.
- in_start  input  1  request a new count; sampled only in IDLE.
- in_mines  input  25  mine bitmap; bit i = 1 means cell i holds a mine. Sampled only on the accepted-start edge.
- out_counts  output  100  4 bits per cell, cell i at [4i+3:4i]. Value 0..8 = neighbour mine count; 4'hF = cell is a mine.
- out_mine_total  output  5  number of set bits in the snapshot, 0..25.
- out_busy  output  1  high while scanning.
- out_done  output  1  one-cycle pulse when the last cell is written.
- out_valid  output  1  out_counts/out_mine_total complete and stable.

## Operation
- FSM states: IDLE, SCAN.
- IDLE -> SCAN when in_start=1. On that edge:
  - snapshot in_mines into an internal register;
  - clear out_counts and out_mine_total to 0;
  - set index=0, out_busy=1, out_valid=0.
- SCAN, one cell per edge, for cell = index:
  - mine at cell: write 4'hF and increment out_mine_total;
  - no mine: write the sum of snapshot bits of in-bounds neighbours (row±1, col±1, excluding self).
  - Then index++.
- Bounds rule: a neighbour is counted only if 0<=row'<=4 and 0<=col'<=4. No horizontal wrap: cell 4 is not adjacent to cell 5, cell 9 is not adjacent to cell 10, and so on.
- Adder width: 4-bit neighbour sum (max 8); out_mine_total is 5-bit (max 25); no overflow is possible.
- When index=24 is written: out_done=1 for exactly one cycle, out_valid=1, out_busy=0, return to IDLE.
- Outputs hold their values in IDLE until the next accepted start.
- in_start while in SCAN: ignored, with no restart and no queuing.
- in_start held high across done: a new scan starts on the first IDLE edge where it is sampled (the edge after done). That start clears out_valid.
- in_mines changes during SCAN: no effect, because only the snapshot is used.

## Timing
- Reset (in_rst_n=0 at a falling edge), from any state including mid-SCAN, returns the block to IDLE with:
  - out_counts=0, out_mine_total=0;
  - out_busy=0, out_done=0, out_valid=0;
  - index=0, snapshot=0.
- Reset has priority over in_start on the same edge.
- Start accepted at edge E0. Cell i is written at edge E(i+1). out_done and out_valid go high after E25. Latency from start to done is 25 cycles.
- out_busy is high after E0 through E24 and low after E25.
- out_done is high only between E25 and E26.
- Earliest restart: start sampled at E26, giving a minimum period of 26 cycles.
- out_counts fields for cells not yet written read 0 while busy; consumers must wait for out_valid.

## Test plan
- Empty board (in_mines=0): start -> all 25 fields 0, out_mine_total=0, out_done pulses exactly 25 cycles after the start edge, out_busy high for 25 cycles.
- Centre mine (bit 12 only):
  - cells 6,7,8,11,13,16,17,18 = 1;
  - cell 12 = 4'hF;
  - all other cells = 0;
  - out_mine_total=1.
- Edge/wrap check (bits 4 and 20):
  - cells 3,8,9 = 1 and cells 15,16,21 = 1;
  - cells 5, 10 and 24 = 0 (no wrap);
  - cells 4 and 20 = 4'hF;
  - out_mine_total=2.
- Full board (25'h1FFFFFF): every field 4'hF, out_mine_total=25. Then bits 0..23 set with cell 24 clear: cell 24 = 3.
- Protocol:
  - start pulses during SCAN cause no restart and no extra done;
  - in_mines toggled mid-scan leaves results matching the snapshot;
  - in_start held high produces back-to-back scans with done every 26 cycles.
- Reset mid-scan (in_rst_n=0 at E10): all outputs are 0 on the next cycle and the FSM is in IDLE. A fresh start then yields correct counts with done 25 cycles later.
